led_mode_ctrl: RTL and testbench

//  Mode controller for the 8-LED pattern generator: drives its 2-bit ctrl

---
 rtl/led_mode_ctrl.sv | 135 +++++++++++++
 tb/tb_led_mode_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_ctrl.sv
// Mode controller for the 8-LED pattern generator. It debounces two active-low
// keys and steps the 2-bit pattern mode, either by hand or on a fixed auto period.
module led_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 240_000,
  parameter int AUTO_PERIOD  = 48_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next_n,
  input  logic       key_auto_n,
  output logic [1:0] ctrl,
  output logic       auto_on,
  output logic       mode_chg
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int AT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_PERIOD - 1);

  localparam int K_NEXT = 0;
  localparam int K_AUTO = 1;

  logic [1:0] key_raw_n;
  logic [1:0] press_evt;

  assign key_raw_n = {key_auto_n, key_next_n};

  // Per key: 2-FF synchroniser, stability counter, accepted level, press edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    always_comb begin
      sync1_d  = key_raw_n[gi];
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
      press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b1;
        cnt_q    <= '0;
        press_q  <= 1'b0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        press_q  <= press_d;
      end
    end

    assign press_evt[gi] = press_q;
  end

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AT_W-1:0] timer_q, timer_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            mode_chg_q, mode_chg_d;
  logic            step;

  // All step sources merge into one step so coincident events advance by one.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step    = press_evt[K_NEXT];
    if (state_q == AUTO && timer_q == AT_LAST) begin
      step = 1'b1;
    end
    ctrl_d     = step ? ctrl_q + 2'd1 : ctrl_q;
    mode_chg_d = step;
    case (state_q)
      MANUAL: begin
        timer_d = '0;
        if (press_evt[K_AUTO]) begin
          state_d = AUTO;
        end
      end
      AUTO: begin
        if (press_evt[K_AUTO]) begin
          state_d = MANUAL;
          timer_d = '0;
        end else if (step) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + AT_W'(1);
        end
      end
      default: begin
        state_d = MANUAL;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MANUAL;
      timer_q    <= '0;
      ctrl_q     <= 2'd0;
      mode_chg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ctrl_q     <= ctrl_d;
      mode_chg_q <= mode_chg_d;
    end
  end

  assign ctrl     = ctrl_q;
  assign auto_on  = (state_q == AUTO);
  assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl. The stimulus queues expected output events
// with their exact cycle, and a negedge monitor pops and compares them.
module tb_led_mode_ctrl;

  localparam int DC     = 8;
  localparam int AP     = 64;
  localparam int LAT    = DC + 3;
  localparam int HOLD   = 14;
  localparam int SETTLE = DC + 6;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       key_next_n = 1'b1;
  logic       key_auto_n = 1'b1;
  logic [1:0] ctrl;
  logic       auto_on;
  logic       mode_chg;

  led_mode_ctrl #(.DEBOUNCE_CYC(DC), .AUTO_PERIOD(AP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_next_n (key_next_n),
    .key_auto_n (key_auto_n),
    .ctrl       (ctrl),
    .auto_on    (auto_on),
    .mode_chg   (mode_chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ctrl;
    logic       auto_on;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         cyc       = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;
  logic [1:0] prev_ctrl = 2'd0;
  logic       prev_auto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // An event is any mode_chg pulse or any change of ctrl or auto_on.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", int'({ctrl, auto_on, mode_chg}), 0);
      prev_ctrl = 2'd0;
      prev_auto = 1'b0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check("missed_event_cycle", cyc, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
      if (mode_chg || ctrl != prev_ctrl || auto_on != prev_auto) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event_ctrl_auto_chg", int'({ctrl, auto_on, mode_chg}),
                int'({prev_ctrl, prev_auto, 1'b0}));
        end else begin
          mon_e = sb_q.pop_front();
          check("event_cycle", cyc, mon_e.cyc);
          check("event_ctrl", int'(ctrl), int'(mon_e.ctrl));
          check("event_auto_on", int'(auto_on), int'(mon_e.auto_on));
          check("event_mode_chg", int'(mode_chg), int'(mon_e.ctrl != prev_ctrl));
        end
        $display("cycle %0d: ctrl=%0d auto_on=%0d mode_chg=%0d", cyc, ctrl, auto_on, mode_chg);
      end
      prev_ctrl = ctrl;
      prev_auto = auto_on;
    end
  end

  task automatic expect_evt(input int at, input logic [1:0] c, input logic a);
    exp_t e;
    e.cyc     = at;
    e.ctrl    = c;
    e.auto_on = a;
    sb_q.push_back(e);
  endtask

  task automatic press(input logic nxt, input logic aut);
    if (nxt) key_next_n = 1'b0;
    if (aut) key_auto_n = 1'b0;
    repeat (HOLD) @(negedge clk);
    key_next_n = 1'b1;
    key_auto_n = 1'b1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    int         a;
    logic [1:0] c;
    logic [1:0] wrap_exp [4];
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};

    // 1: reset with keys toggling
    #1 rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_next_n = i[0];
      key_auto_n = ~i[0];
    end
    @(negedge clk);
    key_next_n = 1'b1;
    key_auto_n = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    settle();

    // 2: bouncing key, only the final long low counts
    for (int i = 0; i < 3; i++) begin
      key_next_n = 1'b0;
      repeat ((i == 0) ? 5 : 3) @(negedge clk);
      key_next_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    expect_evt(cyc + LAT, 2'd1, 1'b0);
    key_next_n = 1'b0;
    repeat (20) @(negedge clk);
    key_next_n = 1'b1;
    settle();

    // 3: wrap from 0 through four manual presses
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      expect_evt(cyc + LAT, wrap_exp[i], 1'b0);
      press(1'b1, 1'b0);
      settle();
    end
    c = 2'd0;

    // 4: auto stepping, then auto off with no further steps
    n = cyc;
    a = n + LAT;
    expect_evt(a, c, 1'b1);
    expect_evt(a + AP, c + 2'd1, 1'b1);
    expect_evt(a + 2 * AP, c + 2'd2, 1'b1);
    expect_evt(a + 3 * AP, c + 2'd3, 1'b1);
    press(1'b0, 1'b1);
    c = c + 2'd3;
    wait_until(a + 3 * AP + 10);
    expect_evt(cyc + LAT, c, 1'b0);
    press(1'b0, 1'b1);
    repeat (200) @(negedge clk);

    // 5: next press coincides with timer expiry, then both keys together
    n = cyc;
    a = n + LAT;
    expect_evt(a, c, 1'b1);
    expect_evt(a + AP, c + 2'd1, 1'b1);
    expect_evt(a + 2 * AP, c + 2'd2, 1'b1);
    press(1'b0, 1'b1);
    wait_until(a + AP - LAT);
    press(1'b1, 1'b0);
    wait_until(a + 2 * AP + 5);
    expect_evt(cyc + LAT, c + 2'd3, 1'b0);
    press(1'b1, 1'b1);
    settle();
    c = c + 2'd3;

    // auto key coincides with timer expiry: one step, back to manual
    n = cyc;
    a = n + LAT;
    expect_evt(a, c, 1'b1);
    expect_evt(a + AP, c + 2'd1, 1'b0);
    press(1'b0, 1'b1);
    wait_until(a + AP - LAT);
    press(1'b0, 1'b1);
    settle();
    c = c + 2'd1;

    // 6: async reset mid-period with ctrl=2 and timer=40
    n = cyc;
    a = n + LAT;
    expect_evt(a, c, 1'b1);
    expect_evt(a + AP, c + 2'd1, 1'b1);
    expect_evt(a + 2 * AP, c + 2'd2, 1'b1);
    expect_evt(a + 3 * AP, c + 2'd3, 1'b1);
    press(1'b0, 1'b1);
    wait_until(a + 3 * AP + 40);
    check("pre_reset_ctrl", int'(ctrl), 2);
    check("pre_reset_auto_on", int'(auto_on), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", int'(ctrl), 0);
    check("async_reset_auto_on", int'(auto_on), 0);
    check("async_reset_mode_chg", int'(mode_chg), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_reset_ctrl", int'(ctrl), 0);
    check("post_reset_auto_on", int'(auto_on), 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
